z80_bus_responder: RTL and testbench

//  Parametrised memory/IO responder for the tv80s core in directed instruction benches. Replaces ad-hoc
//  mem/io arrays: serves reads and captures writes. Inserts programmable wait states and logs every CPU

---
 rtl/z80_bus_pkg.sv | 18 +
 rtl/z80_wlog_fifo.sv | 65 ++++++
 rtl/z80_bus_responder.sv | 142 ++++++++++++++
 tb/tb_z80_bus_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types for the tv80s bus responder: write-log record and wait FSM states.
package z80_bus_pkg;

    localparam int LOG_ENTRY_W = 25;

    typedef struct packed {
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
    } wlog_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } wstate_t;

endpackage

// File: rtl/z80_wlog_fifo.sv
// Synchronous write-log FIFO; a push into a full FIFO is dropped and flagged
// sticky in ovf unless a pop frees the slot in the same cycle.
module z80_wlog_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign valid   = (count_q != '0);
    assign do_pop  = pop & valid;
    // Pop happens first, so a full FIFO still accepts a push paired with a pop.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ovf_d    = ovf_q | (push & ~do_push);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head  = store[rd_ptr_q];
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Memory/IO responder for tv80s benches with write log and optional wait states.
// Wait-state FSM is built only when Z80RSP_WAIT_EN is defined.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int IO_W      = 8,
    parameter int LOG_DEPTH = 16,
    parameter int WAIT_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  a,
    input  logic [7:0]                   dout,
    input  logic                         mreq_n,
    input  logic                         iorq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    output logic [7:0]                   di,
    output logic                         wait_n,
    input  logic [WAIT_W-1:0]            wait_cnt,
    input  logic                         load_we,
    input  logic                         load_io,
    input  logic [ADDR_W-1:0]            load_addr,
    input  logic [7:0]                   load_data,
    input  logic                         log_pop,
    output logic                         log_valid,
    output wlog_t                        log_entry,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         log_ovf
);
    localparam int MEM_D = 1 << ADDR_W;
    localparam int IO_D  = 1 << IO_W;

    logic [7:0] mem [MEM_D];
    logic [7:0] io  [IO_D];
    logic [7:0] mem_q, io_q;
    logic       access, wr_prev_q, wr_edge;
    logic       log_full;
    wlog_t      push_entry;

    assign access     = ~wr_n & (~mreq_n | ~iorq_n);
    assign wr_edge    = access & ~wr_prev_q & ~reset;
    assign push_entry = '{io: ~iorq_n, addr: a, data: dout};

    // CPU write is applied after the preload so it wins on a same-address clash.
    always_ff @(posedge clk) begin
        if (load_we) begin
            if (load_io) io[load_addr[IO_W-1:0]] <= load_data;
            else         mem[load_addr]          <= load_data;
        end
        if (wr_edge) begin
            if (!iorq_n) io[a[IO_W-1:0]]    <= dout;
            else         mem[a[ADDR_W-1:0]] <= dout;
        end
    end

    // Held across reset so a strobe already low when reset drops is never logged.
    always_ff @(posedge clk) begin
        wr_prev_q <= access;
        if (reset) begin
            mem_q <= 8'h00;
            io_q  <= 8'h00;
        end else begin
            mem_q <= mem[a[ADDR_W-1:0]];
            io_q  <= io[a[IO_W-1:0]];
        end
    end

    assign di = !iorq_n ? io_q : mem_q;

    z80_wlog_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_ENTRY_W)
    ) u_log (
        .clk   (clk),
        .reset (reset),
        .push  (wr_edge),
        .din   (push_entry),
        .pop   (log_pop),
        .valid (log_valid),
        .head  (log_entry),
        .full  (log_full),
        .count (log_count),
        .ovf   (log_ovf)
    );

`ifdef Z80RSP_WAIT_EN
    wstate_t             st_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                wait_n_q, req_prev_q;
    logic                req, start;
    logic                unused_full;

    assign req   = ~(mreq_n & iorq_n);
    // Refresh cycles assert mreq_n with both strobes high; they get no waits.
    assign start = req & ~req_prev_q & ~(rd_n & wr_n) & (wait_cnt != '0);

    always_ff @(posedge clk) begin
        req_prev_q <= req;
        if (reset) begin
            st_q     <= IDLE;
            wait_n_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (start) begin
                        st_q     <= WAIT;
                        wait_n_q <= 1'b0;
                        cnt_q    <= wait_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        st_q     <= RELEASE;
                        wait_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    if (!req) st_q <= IDLE;
                end
                default: begin
                    st_q     <= IDLE;
                    wait_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign wait_n      = wait_n_q;
    assign unused_full = log_full;
`else
    logic unused_wait;

    assign wait_n      = 1'b1;
    assign unused_wait = ^{wait_cnt, rd_n, log_full};
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: bus cycles are driven by hand
// in place of a tv80s core.
module tb_z80_bus_responder;
    import z80_bus_pkg::*;

`ifdef Z80RSP_WAIT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0]  di;
    logic        wait_n;
    logic [3:0]  wait_cnt = 4'd0;
    logic        load_we = 1'b0, load_io = 1'b0;
    logic [15:0] load_addr = 16'h0000;
    logic [7:0]  load_data = 8'h00;
    logic        log_pop = 1'b0;
    logic        log_valid;
    wlog_t       log_entry;
    logic [4:0]  log_count;
    logic        log_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    z80_bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .dout      (dout),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .di        (di),
        .wait_n    (wait_n),
        .wait_cnt  (wait_cnt),
        .load_we   (load_we),
        .load_io   (load_io),
        .load_addr (load_addr),
        .load_data (load_data),
        .log_pop   (log_pop),
        .log_valid (log_valid),
        .log_entry (log_entry),
        .log_count (log_count),
        .log_ovf   (log_ovf)
    );

    typedef struct {
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [24:0] exp_log;
        logic [7:0]  exp_rd;
    } wvec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic io, input logic [15:0] ad, input logic [7:0] d);
        load_we = 1'b1; load_io = io; load_addr = ad; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic cpu_write(input logic io, input logic [15:0] ad, input logic [7:0] d);
        a = ad; dout = d;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        tick();
        wr_n = 1'b0;
        tick(); tick(); tick();
        wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        tick();
    endtask

    task automatic cpu_read(input logic io, input logic [15:0] ad, output logic [7:0] d);
        a = ad;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        rd_n = 1'b0;
        tick(); tick();
        d = di;
        rd_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        tick();
    endtask

    task automatic pop_one();
        log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (wait_n === 1'b0) lows++;
        end
    endtask

    wvec_t      vecs [5];
    logic [7:0] rd;
    int         lows;

    initial begin
        vecs[0] = '{1'b0, 16'h8000, 8'h5A, {1'b0, 16'h8000, 8'h5A}, 8'h5A};
        vecs[1] = '{1'b1, 16'h0020, 8'hC3, {1'b1, 16'h0020, 8'hC3}, 8'hC3};
        vecs[2] = '{1'b0, 16'h1234, 8'hA5, {1'b0, 16'h1234, 8'hA5}, 8'hA5};
        vecs[3] = '{1'b1, 16'h00FF, 8'h01, {1'b1, 16'h00FF, 8'h01}, 8'h01};
        vecs[4] = '{1'b0, 16'hFFFF, 8'h80, {1'b0, 16'hFFFF, 8'h80}, 8'h80};

        tick(); tick();
        chk("rst_wait_n", 32'(wait_n), 32'd1);
        chk("rst_di", 32'(di), 32'h00);
        chk("rst_valid", 32'(log_valid), 32'd0);
        chk("rst_count", 32'(log_count), 32'd0);
        chk("rst_ovf", 32'(log_ovf), 32'd0);
        reset = 1'b0;
        tick();

        preload(1'b0, 16'h0000, 8'hFD);
        preload(1'b0, 16'h0001, 8'hCB);
        preload(1'b0, 16'h0002, 8'hA0);
        preload(1'b0, 16'h0003, 8'hA5);
        preload(1'b0, 16'hF141, 8'h44);
        preload(1'b0, 16'h0020, 8'h77);
        preload(1'b1, 16'h0041, 8'h9E);
        cpu_read(1'b0, 16'h0000, rd); chk("pre_rd0", 32'(rd), 32'hFD);
        cpu_read(1'b0, 16'h0003, rd); chk("pre_rd3", 32'(rd), 32'hA5);
        cpu_read(1'b0, 16'hF141, rd); chk("pre_f141", 32'(rd), 32'h44);
        cpu_read(1'b1, 16'h0041, rd); chk("pre_io41", 32'(rd), 32'h9E);
        chk("pre_nolog", 32'(log_valid), 32'd0);
        chk("pre_ovf", 32'(log_ovf), 32'd0);

        for (int i = 0; i < 5; i++) begin
            cpu_write(vecs[i].io, vecs[i].addr, vecs[i].data);
            chk($sformatf("v%0d_count", i), 32'(log_count), 32'd1);
            chk($sformatf("v%0d_entry", i), 32'(log_entry), 32'(vecs[i].exp_log));
            pop_one();
            chk($sformatf("v%0d_empty", i), 32'(log_count), 32'd0);
            cpu_read(vecs[i].io, vecs[i].addr, rd);
            chk($sformatf("v%0d_rdback", i), 32'(rd), 32'(vecs[i].exp_rd));
        end
        cpu_read(1'b0, 16'h0020, rd);
        chk("io_not_mem", 32'(rd), 32'h77);

        a = 16'h4000; dout = 8'h22; mreq_n = 1'b0; wr_n = 1'b0;
        load_we = 1'b1; load_io = 1'b0; load_addr = 16'h4000; load_data = 8'h11;
        tick();
        load_we = 1'b0;
        tick();
        wr_n = 1'b1; mreq_n = 1'b1;
        tick();
        chk("clash_count", 32'(log_count), 32'd1);
        chk("clash_entry", 32'(log_entry), 32'({1'b0, 16'h4000, 8'h22}));
        pop_one();
        cpu_read(1'b0, 16'h4000, rd);
        chk("clash_rd", 32'(rd), 32'h22);

        wait_cnt = 4'd3;
        a = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
        count_low(8, lows);
        chk("wait3_lows", 32'(lows), WEN ? 32'd3 : 32'd0);
        chk("wait3_rd", 32'(di), 32'hFD);
        mreq_n = 1'b1; rd_n = 1'b1;
        tick(); tick();
        mreq_n = 1'b0;
        count_low(6, lows);
        chk("refresh_lows", 32'(lows), 32'd0);
        mreq_n = 1'b1;
        tick();
        wait_cnt = 4'd1;
        iorq_n = 1'b0; rd_n = 1'b0; a = 16'h0041;
        count_low(6, lows);
        chk("wait1_io_lows", 32'(lows), WEN ? 32'd1 : 32'd0);
        iorq_n = 1'b1; rd_n = 1'b1;
        wait_cnt = 4'd0;
        tick();
        mreq_n = 1'b0; rd_n = 1'b0;
        count_low(4, lows);
        chk("wait0_lows", 32'(lows), 32'd0);
        mreq_n = 1'b1; rd_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            cpu_write(1'b0, 16'h9000 + 16'(i), 8'(i * 3 + 1));
        end
        chk("ovf_count", 32'(log_count), 32'd16);
        chk("ovf_flag", 32'(log_ovf), 32'd1);
        chk("ovf_head", 32'(log_entry), 32'({1'b0, 16'h9000, 8'h01}));

        a = 16'h9100; dout = 8'hEE; mreq_n = 1'b0; wr_n = 1'b0; log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
        tick();
        wr_n = 1'b1; mreq_n = 1'b1;
        tick();
        chk("pushpop_count", 32'(log_count), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < 15)
                chk($sformatf("drain%0d", k), 32'(log_entry),
                    32'({1'b0, 16'h9000 + 16'(k + 1), 8'((k + 1) * 3 + 1)}));
            else
                chk("drain15", 32'(log_entry), 32'({1'b0, 16'h9100, 8'hEE}));
            pop_one();
        end
        chk("drain_count", 32'(log_count), 32'd0);
        chk("drain_ovf_sticky", 32'(log_ovf), 32'd1);
        pop_one();
        chk("pop_empty_count", 32'(log_count), 32'd0);
        chk("pop_empty_valid", 32'(log_valid), 32'd0);

        cpu_write(1'b0, 16'h8100, 8'h66);
        chk("prerst_count", 32'(log_count), 32'd1);
        wait_cnt = 4'd5;
        a = 16'h8000; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); tick();
        chk("prerst_wait", 32'(wait_n), WEN ? 32'd0 : 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid_wait_n", 32'(wait_n), 32'd1);
        chk("rst_mid_count", 32'(log_count), 32'd0);
        chk("rst_mid_ovf", 32'(log_ovf), 32'd0);
        reset = 1'b0;
        mreq_n = 1'b1; rd_n = 1'b1;
        wait_cnt = 4'd0;
        tick();
        cpu_read(1'b0, 16'h8000, rd);
        chk("rst_mem_kept", 32'(rd), 32'h5A);
        cpu_read(1'b0, 16'h8100, rd);
        chk("rst_mem_kept2", 32'(rd), 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
